// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the icache and dcache
// memory-side masters; one transaction outstanding at a time.
module cache_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 128,
    parameter int BW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_i_addr,
    input  logic [BW-1:0] i_i_byte_en,
    input  logic [DW-1:0] i_i_writedata,
    input  logic          i_i_read,
    input  logic          i_i_write,
    output logic [DW-1:0] o_i_readdata,
    output logic          o_i_readdata_valid,
    output logic          o_i_waitrequest,
    input  logic [AW-1:0] i_d_addr,
    input  logic [BW-1:0] i_d_byte_en,
    input  logic [DW-1:0] i_d_writedata,
    input  logic          i_d_read,
    input  logic          i_d_write,
    output logic [DW-1:0] o_d_readdata,
    output logic          o_d_readdata_valid,
    output logic          o_d_waitrequest,
    output logic [AW-1:0] o_m_addr,
    output logic [BW-1:0] o_m_byte_en,
    output logic [DW-1:0] o_m_writedata,
    output logic          o_m_read,
    output logic          o_m_write,
    input  logic [DW-1:0] i_m_readdata,
    input  logic          i_m_readdata_valid,
    input  logic          i_m_waitrequest,
    output logic [1:0]    o_grant,
    output logic          o_busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUS    = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;

    logic [1:0] state_reg, state_next;
    logic [1:0] grant_reg, grant_next;
    // last_reg = 1 means the dcache owned the most recently completed transaction
    logic       last_reg, last_next;

    logic own_i, own_d, in_bus, in_rdwait;
    logic sel_read, sel_write, req_i, req_d;

    assign own_i     = grant_reg[0];
    assign own_d     = grant_reg[1];
    assign in_bus    = (state_reg == ST_BUS);
    assign in_rdwait = (state_reg == ST_RDWAIT);
    assign req_i     = i_i_read | i_i_write;
    assign req_d     = i_d_read | i_d_write;
    assign sel_read  = (own_i & i_i_read)  | (own_d & i_d_read);
    assign sel_write = (own_i & i_i_write) | (own_d & i_d_write);

    // Grant is zero in IDLE, so the AND-OR mux also yields zero fields there.
    assign o_m_addr      = ({AW{own_i}} & i_i_addr)      | ({AW{own_d}} & i_d_addr);
    assign o_m_byte_en   = ({BW{own_i}} & i_i_byte_en)   | ({BW{own_d}} & i_d_byte_en);
    assign o_m_writedata = ({DW{own_i}} & i_i_writedata) | ({DW{own_d}} & i_d_writedata);
    assign o_m_read      = in_bus & sel_read;
    assign o_m_write     = in_bus & sel_write & ~sel_read;

    assign o_i_waitrequest    = ~(in_bus & own_i) | i_m_waitrequest;
    assign o_d_waitrequest    = ~(in_bus & own_d) | i_m_waitrequest;
    assign o_i_readdata       = i_m_readdata;
    assign o_d_readdata       = i_m_readdata;
    assign o_i_readdata_valid = in_rdwait & own_i & i_m_readdata_valid;
    assign o_d_readdata_valid = in_rdwait & own_d & i_m_readdata_valid;

    assign o_grant = grant_reg;
    assign o_busy  = (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_i && (!req_d || last_reg)) begin
                    grant_next = 2'b01;
                    state_next = ST_BUS;
                end else if (req_d) begin
                    grant_next = 2'b10;
                    state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                if (o_m_read && !i_m_waitrequest) begin
                    state_next = ST_RDWAIT;
                end else if (o_m_write && !i_m_waitrequest) begin
                    last_next  = own_d;
                    grant_next = 2'b00;
                    state_next = ST_IDLE;
                end else if (!sel_read && !sel_write) begin
                    grant_next = 2'b00;
                    state_next = ST_IDLE;
                end
            end
            ST_RDWAIT: begin
                if (i_m_readdata_valid) begin
                    last_next  = own_d;
                    grant_next = 2'b00;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                grant_next = 2'b00;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            grant_reg <= 2'b00;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a transaction-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_i_addr, i_d_addr;
    logic [BW-1:0] i_i_byte_en, i_d_byte_en;
    logic [DW-1:0] i_i_writedata, i_d_writedata;
    logic          i_i_read, i_i_write, i_d_read, i_d_write;
    logic [DW-1:0] o_i_readdata, o_d_readdata;
    logic          o_i_readdata_valid, o_d_readdata_valid;
    logic          o_i_waitrequest, o_d_waitrequest;
    logic [AW-1:0] o_m_addr;
    logic [BW-1:0] o_m_byte_en;
    logic [DW-1:0] o_m_writedata;
    logic          o_m_read, o_m_write;
    logic [DW-1:0] i_m_readdata;
    logic          i_m_readdata_valid, i_m_waitrequest;
    logic [1:0]    o_grant;
    logic          o_busy;

    int checks = 0;
    int errors = 0;
    int write_log[$];

    always #5 clk = ~clk;

    cache_mem_arbiter #(.AW(AW), .DW(DW), .BW(BW)) dut (
        .clk(clk), .rst(rst),
        .i_i_addr(i_i_addr), .i_i_byte_en(i_i_byte_en), .i_i_writedata(i_i_writedata),
        .i_i_read(i_i_read), .i_i_write(i_i_write),
        .o_i_readdata(o_i_readdata), .o_i_readdata_valid(o_i_readdata_valid),
        .o_i_waitrequest(o_i_waitrequest),
        .i_d_addr(i_d_addr), .i_d_byte_en(i_d_byte_en), .i_d_writedata(i_d_writedata),
        .i_d_read(i_d_read), .i_d_write(i_d_write),
        .o_d_readdata(o_d_readdata), .o_d_readdata_valid(o_d_readdata_valid),
        .o_d_waitrequest(o_d_waitrequest),
        .o_m_addr(o_m_addr), .o_m_byte_en(o_m_byte_en), .o_m_writedata(o_m_writedata),
        .o_m_read(o_m_read), .o_m_write(o_m_write),
        .i_m_readdata(i_m_readdata), .i_m_readdata_valid(i_m_readdata_valid),
        .i_m_waitrequest(i_m_waitrequest),
        .o_grant(o_grant), .o_busy(o_busy)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Reference model: who owns the port (0 none, 1 I, 2 D), whether a read has
    // been accepted and data is awaited, and who completed last.
    int   m_owner;
    logic m_wait;
    int   m_last;

    function automatic logic own_rd();
        return (m_owner == 1) ? i_i_read : (m_owner == 2) ? i_d_read : 1'b0;
    endfunction
    function automatic logic own_wr();
        return (m_owner == 1) ? i_i_write : (m_owner == 2) ? i_d_write : 1'b0;
    endfunction
    function automatic logic on_bus();
        return (m_owner != 0) && !m_wait;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= 0;
            m_wait  <= 1'b0;
            m_last  <= 2;
        end else if (m_owner == 0) begin
            if ((i_i_read | i_i_write) && (i_d_read | i_d_write))
                m_owner <= (m_last == 2) ? 1 : 2;
            else if (i_i_read | i_i_write)
                m_owner <= 1;
            else if (i_d_read | i_d_write)
                m_owner <= 2;
        end else if (!m_wait) begin
            if (own_rd() && !i_m_waitrequest)
                m_wait <= 1'b1;
            else if (own_wr() && !i_m_waitrequest) begin
                m_last  <= m_owner;
                m_owner <= 0;
            end else if (!own_rd() && !own_wr())
                m_owner <= 0;
        end else if (i_m_readdata_valid) begin
            m_last  <= m_owner;
            m_owner <= 0;
            m_wait  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic e_rd, e_wr;
        e_rd = on_bus() && own_rd();
        e_wr = on_bus() && own_wr() && !own_rd();
        chk("grant", {126'd0, o_grant},
            (m_owner == 1) ? 128'd1 : (m_owner == 2) ? 128'd2 : 128'd0);
        chk("busy", {127'd0, o_busy}, {127'd0, m_owner != 0});
        chk("m_read", {127'd0, o_m_read}, {127'd0, e_rd});
        chk("m_write", {127'd0, o_m_write}, {127'd0, e_wr});
        chk("i_wait", {127'd0, o_i_waitrequest},
            {127'd0, !(on_bus() && m_owner == 1) || i_m_waitrequest});
        chk("d_wait", {127'd0, o_d_waitrequest},
            {127'd0, !(on_bus() && m_owner == 2) || i_m_waitrequest});
        chk("i_valid", {127'd0, o_i_readdata_valid},
            {127'd0, m_wait && m_owner == 1 && i_m_readdata_valid});
        chk("d_valid", {127'd0, o_d_readdata_valid},
            {127'd0, m_wait && m_owner == 2 && i_m_readdata_valid});
        chk("i_rdata", o_i_readdata, i_m_readdata);
        chk("d_rdata", o_d_readdata, i_m_readdata);
        if (m_owner == 0 || on_bus()) begin
            chk("m_addr", {96'd0, o_m_addr},
                (m_owner == 1) ? {96'd0, i_i_addr} : (m_owner == 2) ? {96'd0, i_d_addr} : 128'd0);
            chk("m_be", {112'd0, o_m_byte_en},
                (m_owner == 1) ? {112'd0, i_i_byte_en} : (m_owner == 2) ? {112'd0, i_d_byte_en} : 128'd0);
            chk("m_wdata", o_m_writedata,
                (m_owner == 1) ? i_i_writedata : (m_owner == 2) ? i_d_writedata : 128'd0);
        end
        if (!rst && o_m_write && !i_m_waitrequest)
            write_log.push_back(o_grant[1] ? 2 : 1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_iwait"}, {127'd0, o_i_waitrequest}, 128'd1);
        chk({tag, "_dwait"}, {127'd0, o_d_waitrequest}, 128'd1);
        chk({tag, "_mrd"},   {127'd0, o_m_read}, 128'd0);
        chk({tag, "_mwr"},   {127'd0, o_m_write}, 128'd0);
        chk({tag, "_grant"}, {126'd0, o_grant}, 128'd0);
        chk({tag, "_busy"},  {127'd0, o_busy}, 128'd0);
        chk({tag, "_ival"},  {127'd0, o_i_readdata_valid}, 128'd0);
        chk({tag, "_dval"},  {127'd0, o_d_readdata_valid}, 128'd0);
        chk({tag, "_maddr"}, {96'd0, o_m_addr}, 128'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_i_addr = 32'h0; i_i_byte_en = '1; i_i_writedata = '0; i_i_read = 0; i_i_write = 0;
        i_d_addr = 32'h0; i_d_byte_en = '1; i_d_writedata = '0; i_d_read = 0; i_d_write = 0;
        i_m_readdata = '0; i_m_readdata_valid = 0; i_m_waitrequest = 0;
        #1;
        chk_reset_outputs("por");
        step(2);
        rst = 1'b0;
        step(1);

        // Single icache read, three-cycle memory latency
        i_i_addr = 32'h0000_1000; i_i_read = 1;
        step(1);
        chk("rd_mread_n1", {127'd0, o_m_read}, 128'd1);
        chk("rd_addr_n1", {96'd0, o_m_addr}, 128'h1000);
        step(1);
        i_i_read = 0;
        chk("rd_mread_off", {127'd0, o_m_read}, 128'd0);
        step(2);
        i_m_readdata = {4{32'hDEADBEEF}}; i_m_readdata_valid = 1;
        #1;
        chk("rd_ivalid", {127'd0, o_i_readdata_valid}, 128'd1);
        chk("rd_dvalid", {127'd0, o_d_readdata_valid}, 128'd0);
        chk("rd_idata", o_i_readdata, {4{32'hDEADBEEF}});
        step(1);
        i_m_readdata_valid = 0;
        chk("rd_idle", {127'd0, o_busy}, 128'd0);

        // Tie after reset: continuous writes from both masters alternate I, D
        rst = 1; step(1); rst = 0;
        write_log.delete();
        i_i_addr = 32'h100; i_i_writedata = 128'h11; i_i_write = 1;
        i_d_addr = 32'h200; i_d_writedata = 128'h22; i_d_write = 1;
        step(8);
        i_i_write = 0; i_d_write = 0;
        chk("rr_count", write_log.size(), 128'd4);
        if (write_log.size() == 4) begin
            chk("rr_0", write_log[0], 128'd1);
            chk("rr_1", write_log[1], 128'd2);
            chk("rr_2", write_log[2], 128'd1);
            chk("rr_3", write_log[3], 128'd2);
        end
        step(1);

        // dcache write stalled by memory for 4 cycles, icache read queued behind it
        i_d_addr = 32'h0000_00D0; i_d_write = 1; i_m_waitrequest = 1;
        step(1);
        i_i_addr = 32'h0000_0340; i_i_read = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("st_mwrite", {127'd0, o_m_write}, 128'd1);
            chk("st_addr", {96'd0, o_m_addr}, 128'hD0);
            chk("st_dwait", {127'd0, o_d_waitrequest}, 128'd1);
            step(1);
        end
        i_m_waitrequest = 0;
        #1;
        chk("st_mwrite5", {127'd0, o_m_write}, 128'd1);
        chk("st_dwait_lo", {127'd0, o_d_waitrequest}, 128'd0);
        chk("st_iwait", {127'd0, o_i_waitrequest}, 128'd1);
        step(1);
        i_d_write = 0;
        step(1);
        chk("st_igrant", {126'd0, o_grant}, 128'd1);
        chk("st_iread", {127'd0, o_m_read}, 128'd1);
        step(1);
        i_i_read = 0;
        step(1);
        i_m_readdata = 128'h1234; i_m_readdata_valid = 1;
        step(1);
        i_m_readdata_valid = 0;

        // dcache read aborted under memory stall; last stays I so a tie goes to D
        i_d_addr = 32'h0000_0400; i_d_read = 1; i_m_waitrequest = 1;
        step(1);
        chk("ab_dgrant", {126'd0, o_grant}, 128'd2);
        step(1);
        i_d_read = 0;
        step(1);
        chk("ab_idle", {127'd0, o_busy}, 128'd0);
        i_m_waitrequest = 0;
        i_i_write = 1; i_d_write = 1;
        step(1);
        chk("ab_tie_d", {126'd0, o_grant}, 128'd2);
        step(1);
        i_i_write = 0; i_d_write = 0;
        step(1);

        // Stray valid while idle
        i_m_readdata_valid = 1;
        #1;
        chk("stray_ival", {127'd0, o_i_readdata_valid}, 128'd0);
        chk("stray_dval", {127'd0, o_d_readdata_valid}, 128'd0);
        step(1);
        i_m_readdata_valid = 0;

        // Reset in RDWAIT; late valid is ignored and I wins the next tie
        i_d_addr = 32'h0000_0500; i_d_read = 1;
        step(2);
        i_d_read = 0;
        chk("mr_busy", {127'd0, o_busy}, 128'd1);
        #2;
        rst = 1;
        #1;
        chk_reset_outputs("mr");
        step(1);
        rst = 0;
        i_m_readdata_valid = 1;
        #1;
        chk("mr_late_dval", {127'd0, o_d_readdata_valid}, 128'd0);
        step(1);
        i_m_readdata_valid = 0;
        i_i_write = 1; i_d_write = 1;
        step(1);
        chk("mr_tie_i", {126'd0, o_grant}, 128'd1);
        step(1);
        i_i_write = 0; i_d_write = 0;
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single external memory port between the instruction-cache and data-cache memory-side masters. It sits between the two `cache` instances' `o_m_*`/`i_m_*` ports and the system memory/bus, and serialises their transactions with round-robin fairness. Only one transaction is outstanding at a time. Both sides use the same read/write, waitrequest and readdata_valid handshake as the cache memory port.

## Interface
Parameters:
- `AW`, default 32: address width (`CacheMemAddrBus`).
- `DW`, default 128: data width (`CacheMemDataBus`).
- `BW`, default `DW/8`: byte-enable width (`CacheMemByteBus`).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_i_addr`/`i_i_byte_en`/`i_i_writedata` in AW/BW/DW: icache command fields.
- `i_i_read`, `i_i_write` in 1: icache request.
- `o_i_readdata` out DW: read data to the icache.
- `o_i_readdata_valid` out 1: read-data valid to the icache.
- `o_i_waitrequest` out 1: stall to the icache.
- `i_d_*` / `o_d_*`: identical set for the dcache.
- `o_m_addr`/`o_m_byte_en`/`o_m_writedata` out AW/BW/DW: memory command fields.
- `o_m_read`, `o_m_write` out 1: memory request.
- `i_m_readdata` in DW, `i_m_readdata_valid` in 1, `i_m_waitrequest` in 1: memory response.
- `o_grant` out 2: current owner, one-hot; bit0 = I, bit1 = D.
- `o_busy` out 1: high when the state is not IDLE.

## Operation
The arbiter has three states, plus a `last` register (I/D).

- **IDLE**
  - Requests are `req_i = i_i_read|i_i_write` and `req_d = i_d_read|i_d_write`.
  - Only one requests: that master becomes owner and the state goes to BUS.
  - Both request: the owner is the master ≠ `last`.
  - No request: stay in IDLE.
  - Owner is registered, so there is no combinational path from a request to `o_m_*`.
- **BUS**
  - The owner's command fields and read/write pass combinationally to `o_m_*`.
  - Owner waitrequest = `i_m_waitrequest`.
  - Write accepted (`o_m_write & ~i_m_waitrequest`): go to IDLE and set `last` = owner.
  - Read accepted (`o_m_read & ~i_m_waitrequest`): go to RDWAIT.
  - Owner drops read and write (abort): go to IDLE; nothing is issued that cycle and `last` is unchanged.
  - Read and write both high from the owner: read has priority; only `o_m_read` is driven.
- **RDWAIT**
  - `o_m_read` = `o_m_write` = 0.
  - On `i_m_readdata_valid`: pulse the owner's `readdata_valid` in the same cycle (combinational), go to IDLE, set `last` = owner.

Rules in every state:
- The non-owner's waitrequest = 1 in every state. The owner's waitrequest = 1 in IDLE and RDWAIT.
- `i_m_readdata` is broadcast to both `o_*_readdata`; only the owner's valid can assert.
- `i_m_readdata_valid` outside RDWAIT is a stray and is ignored.
- When there is no owner (IDLE), `o_m_addr`, `o_m_byte_en` and `o_m_writedata` are driven 0.

Reset (asynchronous, including mid-transaction):
- State → IDLE, `last` = D, so I wins the first tie.
- `o_grant` = 0 and `o_busy` = 0.
- `o_m_read` = `o_m_write` = 0 and the `o_m_*` fields = 0.
- Both waitrequests = 1 and both readdata_valids = 0.
- A read in flight is abandoned; its later `i_m_readdata_valid` is ignored as a stray.

## Timing
- Arbitration costs 1 cycle: a request first seen in IDLE at edge N appears on `o_m_*` in cycle N+1.
- Minimum write occupancy is 2 cycles (IDLE + BUS with no wait). Back-to-back writes from one master therefore issue at most every 2 cycles.
- Read occupancy is 2 + memory latency cycles. Data is delivered in the same cycle as `i_m_readdata_valid`.
- Fairness under continuous requests from both masters: grants alternate I, D, I, D, …
- Masters must hold their command stable while their waitrequest = 1, as the cache port already requires.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` asynchronously between clock edges.
  - Required response: immediately `o_i_waitrequest` = `o_d_waitrequest` = 1, `o_m_read` = `o_m_write` = 0, `o_grant` = 00.
- **Single read:**
  - Stimulus: icache read, addr 0x0000_1000; memory waitrequest 0; valid 3 cycles later with data 0xDEADBEEF…
  - Required response: `o_m_read` for 1 cycle in cycle N+1; `o_i_readdata_valid` coincides with `i_m_readdata_valid`; `o_d_readdata_valid` stays 0; back in IDLE.
- **Tie and round-robin:**
  - Stimulus: both masters issue continuous writes after reset.
  - Required response: memory sees I, D, I, D; each non-granted master's waitrequest stays 1.
- **Memory stall:**
  - Stimulus: dcache write with `i_m_waitrequest` held high for 4 cycles.
  - Required response: `o_m_write` and addr held for 5 cycles; `o_d_waitrequest` follows memory; a concurrent icache request waits until after the write is accepted and is then granted next.
- **Abort and stray valid:**
  - Stimulus 1: the owner drops its read in BUS while memory waitrequest = 1. Required response: return to IDLE, `last` unchanged.
  - Stimulus 2: pulse `i_m_readdata_valid` in IDLE. Required response: neither master's valid asserts.
- **Reset mid-read:**
  - Stimulus: assert reset in RDWAIT, then the memory valid arrives after reset.
  - Required response: valid ignored, state IDLE, next tie granted to I.
